// File: rtl/comparator_seq32.sv
// comparator_seq32 -- sequential multi-nibble magnitude comparator.
//
// This block accepts an operand pair on a valid/ready handshake. It then
// scans the pair one 4-bit slice per cycle, starting with the most
// significant slice. Each slice is compared with comparator4 semantics
// (4-bit unsigned lt/gt). The registered lt/gt/eq verdict is returned on a
// second valid/ready handshake.
//
// Ports:
//   clk_i        clock, all state changes on the rising edge
//   rst_i        asynchronous, active-high reset
//   in_valid_i   operand pair valid
//   in_ready_o   block can accept operands (IDLE only)
//   a_i, b_i     WIDTH-bit operands, latched on acceptance
//   out_valid_o  verdict valid (registered)
//   out_ready_i  consumer accepts verdict
//   lt_o/gt_o/eq_o  registered verdict, exactly one set while out_valid_o
//   busy_o       scan in progress (SCAN only)
//   state_o      current FSM state, for observation
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds its data stable while valid && !ready.
// Ready never depends on valid in the same cycle.
module comparator_seq32 #(
    parameter int WIDTH      = 32,
    parameter bit SIGNED     = 1'b0,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             lt_o,
    output logic             gt_o,
    output logic             eq_o,
    output logic             busy_o,
    output logic [1:0]       state_o
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [IDXW-1:0]   idx_q;
    // Sticky record of the first differing slice, used when not exiting early.
    logic              found_q, rec_lt_q, rec_gt_q;

    logic [3:0] a_s, b_s;
    logic       slice_lt, slice_gt, hit_new, last, finish;
    logic       res_lt, res_gt;

    // Slice select. When comparing signed operands, the top slice has its
    // sign bit inverted. This makes a plain unsigned nibble compare order
    // the operands as two's complement.
    always_comb begin
        a_s = '0;
        b_s = '0;
        for (int i = 0; i < NIB; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_s = a_q[i*4 +: 4];
                b_s = b_q[i*4 +: 4];
            end
        end
        if (SIGNED && (idx_q == IDXW'(NIB - 1))) begin
            a_s[3] = ~a_s[3];
            b_s[3] = ~b_s[3];
        end
    end

    assign slice_lt = (a_s < b_s);
    assign slice_gt = (a_s > b_s);
    assign hit_new  = !found_q && (slice_lt || slice_gt);
    assign last     = (idx_q == '0);
    assign finish   = last || (EARLY_EXIT && hit_new);
    // A recorded earlier difference always wins over the current slice.
    assign res_lt   = found_q ? rec_lt_q : slice_lt;
    assign res_gt   = found_q ? rec_gt_q : slice_gt;

    assign in_ready_o = (state_q == IDLE);
    assign busy_o     = (state_q == SCAN);
    assign state_o    = state_q;

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid_i) state_d = SCAN;
            SCAN:    if (finish) state_d = DONE;
            DONE:    if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered verdict and sticky difference record.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            lt_o        <= 1'b0;
            gt_o        <= 1'b0;
            eq_o        <= 1'b0;
            found_q     <= 1'b0;
            rec_lt_q    <= 1'b0;
            rec_gt_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        found_q  <= 1'b0;
                        rec_lt_q <= 1'b0;
                        rec_gt_q <= 1'b0;
                    end
                end
                SCAN: begin
                    if (hit_new) begin
                        found_q  <= 1'b1;
                        rec_lt_q <= slice_lt;
                        rec_gt_q <= slice_gt;
                    end
                    if (finish) begin
                        out_valid_o <= 1'b1;
                        lt_o        <= res_lt;
                        gt_o        <= res_gt;
                        eq_o        <= !res_lt && !res_gt;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        lt_o        <= 1'b0;
                        gt_o        <= 1'b0;
                        eq_o        <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand latch and slice index. These need no reset because they are
    // always loaded before use.
    always_ff @(posedge clk_i) begin
        if (state_q == IDLE && in_valid_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            idx_q <= IDXW'(NIB - 1);
        end else if (state_q == SCAN && !last) begin
            idx_q <= idx_q - IDXW'(1);
        end
    end

endmodule

// File: tb/tb_comparator_seq32.sv
// Bench for comparator_seq32: three instances are driven with directed and
// random operand pairs. Instance 0 is unsigned with early exit, instance 1 is
// signed with early exit, and instance 2 is unsigned with a full scan.
module tb_comparator_seq32;

    localparam int NIB = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  in_valid = '0;
    logic [2:0]  out_ready = '0;
    logic [31:0] a_in [3];
    logic [31:0] b_in [3];
    logic [2:0]  in_ready, out_valid, lt, gt, eq, busy;
    logic [1:0]  state [3];

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    comparator_seq32 #(.WIDTH(32), .SIGNED(1'b0), .EARLY_EXIT(1'b1)) dut_u (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .a_i(a_in[0]), .b_i(b_in[0]), .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
        .lt_o(lt[0]), .gt_o(gt[0]), .eq_o(eq[0]), .busy_o(busy[0]), .state_o(state[0]));

    comparator_seq32 #(.WIDTH(32), .SIGNED(1'b1), .EARLY_EXIT(1'b1)) dut_s (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .a_i(a_in[1]), .b_i(b_in[1]), .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
        .lt_o(lt[1]), .gt_o(gt[1]), .eq_o(eq[1]), .busy_o(busy[1]), .state_o(state[1]));

    comparator_seq32 #(.WIDTH(32), .SIGNED(1'b0), .EARLY_EXIT(1'b0)) dut_f (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
        .a_i(a_in[2]), .b_i(b_in[2]), .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2]),
        .lt_o(lt[2]), .gt_o(gt[2]), .eq_o(eq[2]), .busy_o(busy[2]), .state_o(state[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: verdict from integer comparison of the whole operands.
    // Latency is the distance from the top to the highest differing nibble.
    task automatic model(input int d, input logic [31:0] av, input logic [31:0] bv,
                         output logic el, output logic eg, output logic ee, output int ek);
        int h;
        if (d == 1) begin
            el = $signed(av) < $signed(bv);
            eg = $signed(av) > $signed(bv);
        end else begin
            el = av < bv;
            eg = av > bv;
        end
        ee = (av == bv);
        h = -1;
        for (int i = NIB - 1; i >= 0; i--) begin
            if (h < 0 && av[i*4 +: 4] != bv[i*4 +: 4]) h = i;
        end
        if (d == 2 || h < 0) ek = NIB;
        else ek = NIB - h;
    endtask

    task automatic run_txn(input int d, input logic [31:0] av, input logic [31:0] bv,
                           input int hold, input logic el, input logic eg,
                           input logic ee, input int ek);
        int  k;
        int  busy_n;
        bit  seen;
        @(negedge clk);
        for (int w = 0; w < 20 && !in_ready[d]; w++) @(negedge clk);
        chk("in_ready_idle", {31'b0, in_ready[d]}, 32'd1);
        out_ready[d] = (hold == 0);
        in_valid[d]  = 1'b1;
        a_in[d]      = av;
        b_in[d]      = bv;
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        a_in[d]     = $urandom;
        b_in[d]     = $urandom;
        chk("in_ready_after_accept", {31'b0, in_ready[d]}, 32'd0);
        k      = 0;
        busy_n = 0;
        seen   = 0;
        for (int c = 0; c < NIB + 4 && !seen; c++) begin
            if (busy[d]) busy_n++;
            @(posedge clk);
            #1;
            k++;
            if (out_valid[d]) seen = 1;
        end
        chk("verdict_seen", {31'b0, seen}, 32'd1);
        if (!seen) return;
        chk("latency", k, ek);
        chk("busy_cycles", busy_n, ek);
        chk("verdict", {29'b0, lt[d], gt[d], eq[d]}, {29'b0, el, eg, ee});
        chk("busy_done", {31'b0, busy[d]}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_valid[d] = 1'b1;
            a_in[d]     = $urandom;
            b_in[d]     = $urandom;
            @(posedge clk);
            #1;
            chk("hold_verdict", {28'b0, out_valid[d], lt[d], gt[d], eq[d]},
                {28'b0, 1'b1, el, eg, ee});
            chk("hold_in_ready", {31'b0, in_ready[d]}, 32'd0);
        end
        @(negedge clk);
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        chk("released", {27'b0, out_valid[d], lt[d], gt[d], eq[d], in_ready[d]}, 32'd1);
        @(negedge clk);
        out_ready[d] = 1'b0;
    endtask

    task automatic run_model(input int d, input logic [31:0] av, input logic [31:0] bv,
                             input int hold);
        logic el, eg, ee;
        int   ek;
        model(d, av, bv, el, eg, ee, ek);
        run_txn(d, av, bv, hold, el, eg, ee, ek);
    endtask

    initial begin
        int pulses;
        for (int i = 0; i < 3; i++) begin
            a_in[i] = '0;
            b_in[i] = '0;
        end
        // Clock/reset.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_outputs", {26'b0, in_ready[0], out_valid[0], lt[0], gt[0], eq[0], busy[0]},
            32'b100000);

        // Reset during a scan aborts without a verdict.
        @(negedge clk);
        in_valid[0] = 1'b1;
        a_in[0]     = 32'h1234_5678;
        b_in[0]     = 32'h1234_5679;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("busy_before_reset", {31'b0, busy[0]}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_scan_reset", {26'b0, in_ready[0], out_valid[0], lt[0], gt[0], eq[0], busy[0]},
            32'b100000);
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (out_valid[0]) pulses++;
        end
        chk("no_verdict_after_reset", pulses, 0);
        chk("in_ready_after_reset", {31'b0, in_ready[0]}, 32'd1);

        // Directed transactions with expectations written out by hand.
        run_txn(0, 32'hC000_0000, 32'hA000_0000, 0, 1'b0, 1'b1, 1'b0, 1);
        run_txn(0, 32'h0000_000E, 32'h0000_000F, 0, 1'b1, 1'b0, 1'b0, 8);
        run_txn(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 1'b1, 8);
        run_txn(1, 32'h8000_0000, 32'h0000_0001, 0, 1'b1, 1'b0, 1'b0, 1);
        run_txn(0, 32'h8000_0000, 32'h0000_0001, 0, 1'b0, 1'b1, 1'b0, 1);
        run_txn(0, 32'h0000_1100, 32'h0000_1010, 5, 1'b0, 1'b1, 1'b0, 6);
        run_txn(2, 32'hC000_0000, 32'hA000_000F, 0, 1'b0, 1'b1, 1'b0, 8);
        run_txn(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b0, 1'b0, 1'b1, 8);

        // Random transactions checked against the reference model.
        for (int t = 0; t < 36; t++) begin
            int          d, mode, n;
            logic [31:0] av, bv, flip;
            d    = $urandom_range(0, 2);
            mode = $urandom_range(0, 3);
            av   = $urandom;
            bv   = $urandom;
            flip = {28'b0, 4'($urandom_range(1, 15))};
            n    = $urandom_range(0, NIB - 1);
            case (mode)
                1:       bv = av;
                2:       bv = av ^ (flip << (4 * n));
                3:       bv = av ^ 32'h8000_0000;
                default: ;
            endcase
            run_model(d, av, bv, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
